// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - decoupled instruction prefetch queue (PC gen + IF/ID buffer)
// Optional statistics counters: INST_FETCH_QUEUE_STATS_EN
module inst_fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump_en_i,
    input  logic [ADDR_W-1:0]          jump_addr_i,
    input  logic                       hold_i,
    output logic                       fetch_req_o,
    output logic [ADDR_W-1:0]          fetch_addr_o,
    input  logic [INST_W-1:0]          inst_i,
    output logic                       dec_valid_o,
    output logic [INST_W-1:0]          dec_inst_o,
    output logic [ADDR_W-1:0]          dec_inst_addr_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [31:0]                flush_cnt_o,
    output logic [31:0]                stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];

    logic              dec_valid;
    logic              pop;
    logic              push;
    logic              fetch;
    logic [LVL_W-1:0]  occupancy;
    logic              unused_jump_lsbs;

    assign unused_jump_lsbs = ^jump_addr_i[1:0];

    // Counting the in-flight response as occupied guarantees it a slot on arrival.
    always_comb begin
        dec_valid = (level_q != '0) & ~jump_en_i;
        pop       = dec_valid & ~hold_i;
        push      = inflight_q & ~jump_en_i;
        occupancy = level_q + LVL_W'(inflight_q);
        fetch     = ~rst & ~jump_en_i & ((occupancy < LVL_W'(DEPTH)) | pop);
    end

    always_comb begin
        pc_d            = pc_q;
        inflight_d      = inflight_q;
        inflight_addr_d = inflight_addr_q;
        head_d          = head_q;
        tail_d          = tail_q;
        level_d         = level_q;
        inst_mem_d      = inst_mem_q;
        addr_mem_d      = addr_mem_q;
        if (jump_en_i) begin
            pc_d       = {jump_addr_i[ADDR_W-1:2], 2'b00};
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            level_d    = '0;
        end else begin
            if (push) begin
                inst_mem_d[tail_q] = inst_i;
                addr_mem_d[tail_q] = inflight_addr_q;
                tail_d             = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
            inflight_d = fetch;
            if (fetch) begin
                inflight_addr_d = pc_q;
                pc_d            = pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            level_q         <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            level_q         <= level_d;
        end
    end

    // Payload storage needs no reset; level gates what decode sees.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        addr_mem_q <= addr_mem_d;
    end

    assign fetch_req_o     = fetch;
    assign fetch_addr_o    = pc_q;
    assign dec_valid_o     = dec_valid;
    assign dec_inst_o      = (level_q != '0) ? inst_mem_q[head_q] : NOP_INST;
    assign dec_inst_addr_o = (level_q != '0) ? addr_mem_q[head_q] : '0;
    assign level_o         = level_q;

`ifdef INST_FETCH_QUEUE_STATS_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q + {31'b0, jump_en_i};
        stall_cnt_d = stall_cnt_q + {31'b0, ~dec_valid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign flush_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
// Expected statistics depend on INST_FETCH_QUEUE_STATS_EN.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic [31:0] inst_i = '0;
    logic        dec_valid_o;
    logic [31:0] dec_inst_o;
    logic [31:0] dec_inst_addr_o;
    logic [2:0]  level_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
        .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o), .inst_i(inst_i),
        .dec_valid_o(dec_valid_o), .dec_inst_o(dec_inst_o),
        .dec_inst_addr_o(dec_inst_addr_o), .level_o(level_o),
        .flush_cnt_o(flush_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // ROM with one-cycle latency that returns its address as data
    always @(posedge clk) begin
        if (fetch_req_o) inst_i <= fetch_addr_o;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of addresses (data equals address), pc, one in-flight record
    logic [31:0] mq[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_inf_addr = '0;
    bit          m_inf = 1'b0;
    logic [31:0] m_flush = '0;
    logic [31:0] m_stall = '0;

    initial begin
        forever begin
            bit v, p, f;
            logic [31:0] ef, es;
            @(negedge clk);
            v = (mq.size() != 0) && !jump_en_i;
            p = v && !hold_i;
            f = !rst && !jump_en_i && (((mq.size() + int'(m_inf)) < DEPTH) || p);
            if (rst) begin
                check("fetch_req_in_reset", {63'b0, fetch_req_o}, 64'd0);
                mq.delete();
                m_pc = '0; m_inf = 1'b0; m_flush = '0; m_stall = '0;
            end else begin
`ifdef INST_FETCH_QUEUE_STATS_EN
                ef = m_flush; es = m_stall;
`else
                ef = '0; es = '0;
`endif
                check("fetch_req", {63'b0, fetch_req_o}, {63'b0, f});
                check("fetch_addr", {32'b0, fetch_addr_o}, {32'b0, m_pc});
                check("dec_valid", {63'b0, dec_valid_o}, {63'b0, v});
                check("level", {61'b0, level_o}, 64'(mq.size()));
                check("dec_inst", {32'b0, dec_inst_o}, {32'b0, (mq.size() != 0) ? mq[0] : NOP});
                check("dec_inst_addr", {32'b0, dec_inst_addr_o}, {32'b0, (mq.size() != 0) ? mq[0] : 32'h0});
                check("flush_cnt", {32'b0, flush_cnt_o}, {32'b0, ef});
                check("stall_cnt", {32'b0, stall_cnt_o}, {32'b0, es});
                if (jump_en_i) m_flush++;
                if (!v) m_stall++;
                if (jump_en_i) begin
                    mq.delete();
                    m_inf = 1'b0;
                    m_pc = {jump_addr_i[31:2], 2'b00};
                end else begin
                    if (p) void'(mq.pop_front());
                    if (m_inf) mq.push_back(m_inf_addr);
                    m_inf = f;
                    if (f) begin
                        m_inf_addr = m_pc;
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [15:0] hold_pat;
        logic [31:0] exp_f, exp_s;
        hold_pat = 16'b0110_0011_1100_1010;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // cycle 0 after reset release
        settle();
        check("c0_fetch_req", {63'b0, fetch_req_o}, 64'd1);
        check("c0_fetch_addr", {32'b0, fetch_addr_o}, 64'h0);
        check("c0_level", {61'b0, level_o}, 64'd0);
        check("c0_valid", {63'b0, dec_valid_o}, 64'd0);
        check("c0_nop", {32'b0, dec_inst_o}, {32'b0, NOP});
        check("c0_inst_addr", {32'b0, dec_inst_addr_o}, 64'h0);
        next_cycle(); settle();
        check("c1_valid", {63'b0, dec_valid_o}, 64'd0);
        check("c1_fetch_addr", {32'b0, fetch_addr_o}, 64'h4);
        next_cycle(); settle();
        check("c2_valid", {63'b0, dec_valid_o}, 64'd1);
        check("c2_inst_addr", {32'b0, dec_inst_addr_o}, 64'h0);
        next_cycle(); settle();
        check("c3_inst_addr", {32'b0, dec_inst_addr_o}, 64'h4);
        next_cycle(); settle();
        check("c4_inst_addr", {32'b0, dec_inst_addr_o}, 64'h8);
        check("c4_inst", {32'b0, dec_inst_o}, 64'h8);

        // hold for 10 cycles: queue fills and fetching stops
        next_cycle();
        hold_i = 1'b1;
        for (int i = 0; i < 9; i++) next_cycle();
        settle();
        check("hold_level_full", {61'b0, level_o}, 64'd4);
        check("hold_no_fetch", {63'b0, fetch_req_o}, 64'd0);
        check("hold_valid", {63'b0, dec_valid_o}, 64'd1);
        next_cycle();
        hold_i = 1'b0;
        for (int i = 0; i < 6; i++) next_cycle();

        // jump together with hold, misaligned target
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0203; hold_i = 1'b1;
        settle();
        check("j1_valid", {63'b0, dec_valid_o}, 64'd0);
        check("j1_fetch_req", {63'b0, fetch_req_o}, 64'd0);
        next_cycle();
        jump_en_i = 1'b0;
        settle();
        check("j1p1_level", {61'b0, level_o}, 64'd0);
        check("j1p1_fetch_addr", {32'b0, fetch_addr_o}, 64'h200);
        check("j1p1_fetch_req", {63'b0, fetch_req_o}, 64'd1);
        next_cycle();
        next_cycle(); settle();
        check("j1p3_valid", {63'b0, dec_valid_o}, 64'd1);
        check("j1p3_inst_addr", {32'b0, dec_inst_addr_o}, 64'h200);
        next_cycle();
        next_cycle();
        // queue holds 3 entries; redirect to 0x100
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100; hold_i = 1'b0;
        settle();
        check("j2_level3", {61'b0, level_o}, 64'd3);
        check("j2_valid", {63'b0, dec_valid_o}, 64'd0);
        next_cycle();
        jump_en_i = 1'b0;
        settle();
        check("j2p1_level", {61'b0, level_o}, 64'd0);
        check("j2p1_fetch_addr", {32'b0, fetch_addr_o}, 64'h100);
        next_cycle();
        next_cycle(); settle();
        check("j2p3_valid", {63'b0, dec_valid_o}, 64'd1);
        check("j2p3_inst_addr", {32'b0, dec_inst_addr_o}, 64'h100);
        check("j2p3_inst", {32'b0, dec_inst_o}, 64'h100);

        for (int i = 0; i < 4; i++) next_cycle();
        for (int i = 0; i < 16; i++) begin
            hold_i = hold_pat[i];
            next_cycle();
        end
        hold_i = 1'b0;

        // address wrap at the top of the space
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
        next_cycle();
        jump_en_i = 1'b0;
        settle();
        check("wrap_a0", {32'b0, fetch_addr_o}, 64'hFFFF_FFF8);
        next_cycle(); settle();
        check("wrap_a1", {32'b0, fetch_addr_o}, 64'hFFFF_FFFC);
        next_cycle(); settle();
        check("wrap_a2", {32'b0, fetch_addr_o}, 64'h0);
        check("wrap_req", {63'b0, fetch_req_o}, 64'd1);
        check("wrap_head", {32'b0, dec_inst_addr_o}, 64'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) next_cycle();

        // mid-operation reset, then 3 jumps and 5 empty cycles
        rst = 1'b1;
        settle();
        check("rst_fetch_req", {63'b0, fetch_req_o}, 64'd0);
        next_cycle();
        rst = 1'b0;
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0080;
        next_cycle();
        next_cycle();
        next_cycle();
        jump_en_i = 1'b0;
        settle();
        check("st_fetch_addr", {32'b0, fetch_addr_o}, 64'h80);
        next_cycle();
        next_cycle(); settle();
`ifdef INST_FETCH_QUEUE_STATS_EN
        exp_f = 32'd3; exp_s = 32'd5;
`else
        exp_f = 32'd0; exp_s = 32'd0;
`endif
        check("st_valid", {63'b0, dec_valid_o}, 64'd1);
        check("st_inst_addr", {32'b0, dec_inst_addr_o}, 64'h80);
        check("st_flush_cnt", {32'b0, flush_cnt_o}, {32'b0, exp_f});
        check("st_stall_cnt", {32'b0, stall_cnt_o}, {32'b0, exp_s});
        next_cycle();
        next_cycle(); settle();
        check("st_flush_cnt2", {32'b0, flush_cnt_o}, {32'b0, exp_f});
        check("st_stall_cnt2", {32'b0, stall_cnt_o}, {32'b0, exp_s});
        next_cycle();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
